lsu_dtag_wrdp: RTL and testbench

- Write-side datapath for the L1 D-cache tag and valid arrays; the counterpart of the tag read/parity-check path.
- Accepts three request sources:
  - line fills from the CPX return path;
  - diagnostic ASI tag writes;
  - parity-error invalidates raised by dctl.
- Generates the tag parity bit, arbitrates between the sources and holds the winner until the array grants a write slot.
- Issues the dtag write and the matching dva write.

---
 rtl/lsu_dtag_wrdp_if.sv | 43 ++++
 rtl/lsu_dtag_wrdp.sv | 119 +++++++++++
 tb/tb_lsu_dtag_wrdp.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_dtag_wrdp_if.sv
// lsu_dtag_wrdp_if: request sources and tag/valid array write bundle for the D-cache tag write datapath
interface lsu_dtag_wrdp_if #(parameter int TAG_W = 29, parameter int IDX_W = 7, parameter int WAYS = 4);
  logic             fill_vld;
  logic             fill_rdy;
  logic [IDX_W-1:0] fill_idx;
  logic [WAYS-1:0]  fill_way;
  logic [TAG_W-1:0] fill_tag;
  logic             diag_vld;
  logic             diag_rdy;
  logic [IDX_W-1:0] diag_idx;
  logic [WAYS-1:0]  diag_way;
  logic [TAG_W-1:0] diag_tag;
  logic             perr_vld;
  logic [IDX_W-1:0] perr_idx;
  logic [WAYS-1:0]  perr_mask;
  logic             perr_drop;
  logic             arr_wr_gnt;
  logic             dtag_wr_en;
  logic [IDX_W-1:0] dtag_wr_idx;
  logic [WAYS-1:0]  dtag_wr_way;
  logic [TAG_W:0]   dtag_wr_data;
  logic             dva_wr_en;
  logic [IDX_W-1:0] dva_wr_idx;
  logic [WAYS-1:0]  dva_wr_mask;
  logic             dva_wr_val;
  logic             busy;
  modport slave (
    input  fill_vld, fill_idx, fill_way, fill_tag,
    input  diag_vld, diag_idx, diag_way, diag_tag,
    input  perr_vld, perr_idx, perr_mask, arr_wr_gnt,
    output fill_rdy, diag_rdy, perr_drop,
    output dtag_wr_en, dtag_wr_idx, dtag_wr_way, dtag_wr_data,
    output dva_wr_en, dva_wr_idx, dva_wr_mask, dva_wr_val, busy
  );
  modport master (
    output fill_vld, fill_idx, fill_way, fill_tag,
    output diag_vld, diag_idx, diag_way, diag_tag,
    output perr_vld, perr_idx, perr_mask, arr_wr_gnt,
    input  fill_rdy, diag_rdy, perr_drop,
    input  dtag_wr_en, dtag_wr_idx, dtag_wr_way, dtag_wr_data,
    input  dva_wr_en, dva_wr_idx, dva_wr_mask, dva_wr_val, busy
  );
endinterface

// File: rtl/lsu_dtag_wrdp.sv
// lsu_dtag_wrdp: D-cache tag/valid write datapath; arbitrates fill, diag and parity invalidates.
// Optional LSU_DTAG_PAR_INJECT_EN adds par_inj_en to force bad parity on diagnostic writes.
module lsu_dtag_wrdp #(
  parameter int TAG_W = 29,
  parameter int IDX_W = 7,
  parameter int WAYS  = 4
) (
  input logic rclk,
  input logic arst_l,
`ifdef LSU_DTAG_PAR_INJECT_EN
  input logic par_inj_en,
`endif
  lsu_dtag_wrdp_if.slave io
);
  typedef enum logic {IDLE, ISSUE} state_t;
  typedef enum logic [1:0] {K_NONE, K_FILL, K_DIAG, K_PERR} kind_t;
  state_t state_q, state_d;
  kind_t kind_q, kind_d;
  logic fill_held_q, fill_held_d, diag_held_q, diag_held_d, perr_held_q, perr_held_d;
  logic [IDX_W-1:0] fill_idx_q, fill_idx_d, diag_idx_q, diag_idx_d, perr_idx_q, perr_idx_d;
  logic [IDX_W-1:0] iss_idx_q, iss_idx_d;
  logic [WAYS-1:0] fill_way_q, fill_way_d, diag_way_q, diag_way_d, perr_mask_q, perr_mask_d;
  logic [WAYS-1:0] iss_way_q, iss_way_d;
  logic [TAG_W-1:0] fill_tag_q, fill_tag_d, diag_tag_q, diag_tag_d;
  logic [TAG_W:0] iss_data_q, iss_data_d;
  logic perr_drop_q, perr_drop_d;
  logic idle, take_perr, take_fill, take_diag, fill_acc, diag_acc, perr_live, perr_new, perr_hit, inj, strobe;
`ifdef LSU_DTAG_PAR_INJECT_EN
  assign inj = par_inj_en;
`else
  assign inj = 1'b0;
`endif
  always_comb begin
    idle = state_q == IDLE;
    take_perr = idle && perr_held_q;
    take_fill = idle && !perr_held_q && fill_held_q;
    take_diag = idle && !perr_held_q && !fill_held_q && diag_held_q;
    fill_acc = io.fill_vld && !fill_held_q;
    diag_acc = io.diag_vld && !diag_held_q;
    fill_held_d = fill_acc || (fill_held_q && !take_fill);
    diag_held_d = diag_acc || (diag_held_q && !diag_held_q_taken(take_diag));
    fill_idx_d = fill_acc ? io.fill_idx : fill_idx_q;
    fill_way_d = fill_acc ? io.fill_way : fill_way_q;
    fill_tag_d = fill_acc ? io.fill_tag : fill_tag_q;
    diag_idx_d = diag_acc ? io.diag_idx : diag_idx_q;
    diag_way_d = diag_acc ? io.diag_way : diag_way_q;
    diag_tag_d = diag_acc ? io.diag_tag : diag_tag_q;
    // an entry leaving for the issue register this cycle frees its slot for a fresh capture
    perr_live = perr_held_q && !take_perr;
    perr_new = io.perr_vld && !perr_live;
    perr_hit = io.perr_vld && perr_live && io.perr_idx == perr_idx_q;
    perr_drop_d = io.perr_vld && perr_live && io.perr_idx != perr_idx_q;
    perr_held_d = perr_new || perr_live;
    perr_idx_d = perr_new ? io.perr_idx : perr_idx_q;
    perr_mask_d = perr_new ? io.perr_mask : perr_hit ? perr_mask_q | io.perr_mask : perr_mask_q;
    state_d = idle ? ((perr_held_q || fill_held_q || diag_held_q) ? ISSUE : IDLE)
                   : (io.arr_wr_gnt ? IDLE : ISSUE);
    kind_d = take_perr ? K_PERR : take_fill ? K_FILL : take_diag ? K_DIAG : kind_q;
    iss_idx_d = take_perr ? perr_idx_q : take_fill ? fill_idx_q : take_diag ? diag_idx_q : iss_idx_q;
    iss_way_d = take_perr ? perr_mask_q : take_fill ? fill_way_q : take_diag ? diag_way_q : iss_way_q;
    iss_data_d = take_fill ? {^fill_tag_q, fill_tag_q}
               : take_diag ? {(^diag_tag_q) ^ inj, diag_tag_q} : iss_data_q;
  end
  function automatic logic diag_held_q_taken(input logic t);
    return t;
  endfunction
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q <= IDLE;
      kind_q <= K_NONE;
      fill_held_q <= 1'b0;
      diag_held_q <= 1'b0;
      perr_held_q <= 1'b0;
      fill_idx_q <= '0;
      fill_way_q <= '0;
      fill_tag_q <= '0;
      diag_idx_q <= '0;
      diag_way_q <= '0;
      diag_tag_q <= '0;
      perr_idx_q <= '0;
      perr_mask_q <= '0;
      perr_drop_q <= 1'b0;
      iss_idx_q <= '0;
      iss_way_q <= '0;
      iss_data_q <= '0;
    end else begin
      state_q <= state_d;
      kind_q <= kind_d;
      fill_held_q <= fill_held_d;
      diag_held_q <= diag_held_d;
      perr_held_q <= perr_held_d;
      fill_idx_q <= fill_idx_d;
      fill_way_q <= fill_way_d;
      fill_tag_q <= fill_tag_d;
      diag_idx_q <= diag_idx_d;
      diag_way_q <= diag_way_d;
      diag_tag_q <= diag_tag_d;
      perr_idx_q <= perr_idx_d;
      perr_mask_q <= perr_mask_d;
      perr_drop_q <= perr_drop_d;
      iss_idx_q <= iss_idx_d;
      iss_way_q <= iss_way_d;
      iss_data_q <= iss_data_d;
    end
  end
  assign strobe = state_q == ISSUE && io.arr_wr_gnt;
  assign io.fill_rdy = !fill_held_q;
  assign io.diag_rdy = !diag_held_q;
  assign io.perr_drop = perr_drop_q;
  assign io.dtag_wr_en = strobe && kind_q != K_PERR;
  assign io.dtag_wr_idx = iss_idx_q;
  assign io.dtag_wr_way = iss_way_q;
  assign io.dtag_wr_data = iss_data_q;
  assign io.dva_wr_en = strobe && kind_q != K_DIAG;
  assign io.dva_wr_idx = iss_idx_q;
  assign io.dva_wr_mask = iss_way_q;
  assign io.dva_wr_val = kind_q == K_FILL;
  assign io.busy = fill_held_q || diag_held_q || perr_held_q || state_q == ISSUE;
endmodule

// File: tb/tb_lsu_dtag_wrdp.sv
// tb_lsu_dtag_wrdp: vector table plus corner-case sequences, checked through an expected-write queue.
module tb_lsu_dtag_wrdp;
  localparam int TAG_W = 29;
  localparam int IDX_W = 7;
  localparam int WAYS = 4;
  typedef struct {
    logic te; logic [IDX_W-1:0] ti; logic [WAYS-1:0] tw; logic [TAG_W:0] td;
    logic ve; logic [IDX_W-1:0] vi; logic [WAYS-1:0] vm; logic vv;
  } wr_t;
  typedef struct {
    int kind; logic [IDX_W-1:0] idx; logic [WAYS-1:0] way; logic [TAG_W-1:0] tag;
    logic te; logic [TAG_W:0] td; logic ve; logic vv;
  } vec_t;
  logic rclk = 1'b0;
  logic arst_l = 1'b0;
`ifdef LSU_DTAG_PAR_INJECT_EN
  logic par_inj_en = 1'b0;
`endif
  int compared = 0;
  int mismatched = 0;
  wr_t exp_q[$];
  vec_t tbl[8];
  lsu_dtag_wrdp_if #(.TAG_W(TAG_W), .IDX_W(IDX_W), .WAYS(WAYS)) io();
  lsu_dtag_wrdp #(.TAG_W(TAG_W), .IDX_W(IDX_W), .WAYS(WAYS)) dut (
    .rclk(rclk),
    .arst_l(arst_l),
`ifdef LSU_DTAG_PAR_INJECT_EN
    .par_inj_en(par_inj_en),
`endif
    .io(io)
  );
  always #5 rclk = ~rclk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  function automatic wr_t mk(input logic te, input logic [IDX_W-1:0] idx, input logic [WAYS-1:0] way,
                             input logic [TAG_W:0] td, input logic ve, input logic vv);
    wr_t w;
    w.te = te; w.ti = idx; w.tw = way; w.td = td;
    w.ve = ve; w.vi = idx; w.vm = way; w.vv = vv;
    return w;
  endfunction
  always @(negedge rclk) begin
    wr_t e;
    if (io.dtag_wr_en || io.dva_wr_en) begin
      if (exp_q.size() == 0) chk("unexpected_write", {io.dtag_wr_en, io.dva_wr_en}, 0);
      else begin
        e = exp_q.pop_front();
        chk("dtag_wr_en", io.dtag_wr_en, e.te);
        chk("dva_wr_en", io.dva_wr_en, e.ve);
        if (e.te) begin
          chk("dtag_wr_idx", io.dtag_wr_idx, e.ti);
          chk("dtag_wr_way", io.dtag_wr_way, e.tw);
          chk("dtag_wr_data", io.dtag_wr_data, e.td);
        end
        if (e.ve) begin
          chk("dva_wr_idx", io.dva_wr_idx, e.vi);
          chk("dva_wr_mask", io.dva_wr_mask, e.vm);
          chk("dva_wr_val", io.dva_wr_val, e.vv);
        end
      end
    end
  end
  task automatic send(input int kind, input logic [IDX_W-1:0] idx, input logic [WAYS-1:0] way,
                      input logic [TAG_W-1:0] tag);
    int n = 0;
    if (kind == 0) begin io.fill_vld = 1; io.fill_idx = idx; io.fill_way = way; io.fill_tag = tag; end
    else if (kind == 1) begin io.diag_vld = 1; io.diag_idx = idx; io.diag_way = way; io.diag_tag = tag; end
    else begin io.perr_vld = 1; io.perr_idx = idx; io.perr_mask = way; end
    while (n < 50 && ((kind == 0 && !io.fill_rdy) || (kind == 1 && !io.diag_rdy))) begin
      @(posedge rclk); #1; n++;
    end
    if (n == 50) chk("send_timeout", n, 0);
    @(posedge rclk); #1;
    io.fill_vld = 0; io.diag_vld = 0; io.perr_vld = 0;
  endtask
  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(posedge rclk); #1; n++; end
    chk(nm, exp_q.size(), 0);
  endtask
  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin @(posedge rclk); #1; end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{0, 7'h05, 4'b0010, 29'h0000001, 1'b1, 30'h20000001, 1'b1, 1'b1};
    tbl[1] = '{0, 7'h7F, 4'b1000, 29'h1FFFFFFF, 1'b1, 30'h3FFFFFFF, 1'b1, 1'b1};
    tbl[2] = '{0, 7'h00, 4'b0001, 29'h0000000, 1'b1, 30'h00000000, 1'b1, 1'b1};
    tbl[3] = '{1, 7'h11, 4'b0100, 29'h0000003, 1'b1, 30'h00000003, 1'b0, 1'b0};
    tbl[4] = '{1, 7'h40, 4'b0001, 29'h10000000, 1'b1, 30'h30000000, 1'b0, 1'b0};
    tbl[5] = '{2, 7'h22, 4'b1010, 29'h0000000, 1'b0, 30'h00000000, 1'b1, 1'b0};
    tbl[6] = '{0, 7'h33, 4'b0100, 29'h0AAAAAAA, 1'b1, 30'h0AAAAAAA, 1'b1, 1'b1};
    tbl[7] = '{1, 7'h6A, 4'b1000, 29'h15555555, 1'b1, 30'h35555555, 1'b0, 1'b0};
    io.fill_vld = 0; io.fill_idx = 0; io.fill_way = 0; io.fill_tag = 0;
    io.diag_vld = 0; io.diag_idx = 0; io.diag_way = 0; io.diag_tag = 0;
    io.perr_vld = 0; io.perr_idx = 0; io.perr_mask = 0; io.arr_wr_gnt = 0;
    repeat (3) @(posedge rclk);
    #1 arst_l = 1;
    chk("rst_fill_rdy", io.fill_rdy, 1);
    chk("rst_diag_rdy", io.diag_rdy, 1);
    chk("rst_busy", io.busy, 0);
    chk("rst_strobes", {io.dtag_wr_en, io.dva_wr_en}, 0);
    chk("rst_perr_drop", io.perr_drop, 0);
    chk("rst_data", io.dtag_wr_data, 0);
    io.arr_wr_gnt = 1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(mk(tbl[i].te, tbl[i].idx, tbl[i].way, tbl[i].td, tbl[i].ve, tbl[i].vv));
      send(tbl[i].kind, tbl[i].idx, tbl[i].way, tbl[i].tag);
      drain($sformatf("vec%0d_drain", i));
    end
    // fill and invalidate to the same set together: invalidate must land first
    exp_q.push_back(mk(1'b0, 7'h03, 4'b1111, 30'h0, 1'b1, 1'b0));
    exp_q.push_back(mk(1'b1, 7'h03, 4'b0100, 30'h00000005, 1'b1, 1'b1));
    io.fill_vld = 1; io.fill_idx = 7'h03; io.fill_way = 4'b0100; io.fill_tag = 29'h5;
    io.perr_vld = 1; io.perr_idx = 7'h03; io.perr_mask = 4'b1111;
    @(posedge rclk); #1;
    io.fill_vld = 0; io.perr_vld = 0;
    drain("perr_before_fill");
    exp_q.push_back(mk(1'b1, 7'h0A, 4'b0001, 30'h20000001, 1'b1, 1'b1));
    exp_q.push_back(mk(1'b1, 7'h0B, 4'b0010, 30'h00000003, 1'b0, 1'b0));
    io.fill_vld = 1; io.fill_idx = 7'h0A; io.fill_way = 4'b0001; io.fill_tag = 29'h1;
    io.diag_vld = 1; io.diag_idx = 7'h0B; io.diag_way = 4'b0010; io.diag_tag = 29'h3;
    @(posedge rclk); #1;
    io.fill_vld = 0; io.diag_vld = 0;
    chk("both_held_fill_rdy", io.fill_rdy, 0);
    chk("both_held_diag_rdy", io.diag_rdy, 0);
    drain("fill_then_diag");
    io.arr_wr_gnt = 0;
    send(1, 7'h21, 4'b0001, 29'h0000003);
    chk("diag_rdy_after_accept", io.diag_rdy, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge rclk);
      chk("no_strobe_wo_gnt", {io.dtag_wr_en, io.dva_wr_en}, 0);
    end
    chk("busy_waiting_gnt", io.busy, 1);
    @(posedge rclk); #1;
    exp_q.push_back(mk(1'b1, 7'h21, 4'b0001, 30'h00000003, 1'b0, 1'b0));
    io.arr_wr_gnt = 1;
    drain("diag_late_gnt");
    io.arr_wr_gnt = 0;
    send(0, 7'h01, 4'b0001, 29'h0);
    idle_cycles(2);
    io.perr_vld = 1; io.perr_idx = 7'h02; io.perr_mask = 4'b0001;
    @(posedge rclk); #1;
    chk("perr_drop_first", io.perr_drop, 0);
    io.perr_mask = 4'b0100;
    @(posedge rclk); #1;
    chk("perr_drop_merge", io.perr_drop, 0);
    io.perr_idx = 7'h09; io.perr_mask = 4'b1000;
    @(posedge rclk); #1;
    io.perr_vld = 0;
    chk("perr_drop_pulse", io.perr_drop, 1);
    @(posedge rclk); #1;
    chk("perr_drop_clear", io.perr_drop, 0);
    exp_q.push_back(mk(1'b1, 7'h01, 4'b0001, 30'h0, 1'b1, 1'b1));
    exp_q.push_back(mk(1'b0, 7'h02, 4'b0101, 30'h0, 1'b1, 1'b0));
    io.arr_wr_gnt = 1;
    drain("perr_merged_mask");
    idle_cycles(3);
`ifdef LSU_DTAG_PAR_INJECT_EN
    par_inj_en = 1;
    exp_q.push_back(mk(1'b1, 7'h12, 4'b0010, 30'h00000001, 1'b0, 1'b0));
    send(1, 7'h12, 4'b0010, 29'h0000001);
    drain("diag_par_inject");
    exp_q.push_back(mk(1'b1, 7'h13, 4'b0010, 30'h20000001, 1'b1, 1'b1));
    send(0, 7'h13, 4'b0010, 29'h0000001);
    drain("fill_ignores_inject");
    par_inj_en = 0;
`endif
    // reset while a write is stalled in issue and another fill is held
    io.arr_wr_gnt = 0;
    send(0, 7'h10, 4'b0001, 29'h7);
    idle_cycles(2);
    send(0, 7'h11, 4'b0010, 29'h8);
    chk("pre_reset_busy", io.busy, 1);
    arst_l = 0;
    io.arr_wr_gnt = 1;
    #1;
    chk("reset_strobes", {io.dtag_wr_en, io.dva_wr_en}, 0);
    repeat (2) @(posedge rclk);
    #1 arst_l = 1;
    chk("post_reset_fill_rdy", io.fill_rdy, 1);
    chk("post_reset_diag_rdy", io.diag_rdy, 1);
    chk("post_reset_busy", io.busy, 0);
    idle_cycles(5);
    chk("post_reset_busy_idle", io.busy, 0);
    exp_q.push_back(mk(1'b1, 7'h2C, 4'b1000, 30'h20000001, 1'b1, 1'b1));
    send(0, 7'h2C, 4'b1000, 29'h0000001);
    drain("post_reset_fill");
    idle_cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
